// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and defaults for spi_master_mc.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LEAD, SHIFT_TRAIL, HOLD, DONE} spi_state_e;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  localparam int SPI_DIV_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/spi_master_mc_clk_gen.sv
// spi_clk_gen: half-period counter, one-cycle tick every div_i+1 enabled cycles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 enable_i,
  input  logic                 restart_i,
  output logic                 tick_o
);
  logic [DIV_WIDTH:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = enable_i && cnt_q == {1'b0, div_i};
    cnt_d = (restart_i || !enable_i || tick_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master with CPOL/CPHA, clock divider and one-hot selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first_i port for LSB-first framing.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int DIV_WIDTH = SPI_DIV_WIDTH_DEFAULT,
  localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic [SEL_W-1:0]      slave_sel_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  spi_clk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic [NUM_SLAVES-1:0] ss_n_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [SEL_W:0] NUM_SEL = (SEL_W + 1)'(NUM_SLAVES);
  spi_state_e state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, lsb_in;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d, tx_shift, rx_in, mosi_src;
  logic [CW-1:0] bit_q, bit_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_SLAVES-1:0] ss_n_q, ss_n_d;
  logic tick, accept, last, lead, trail;
`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first_i;
`else
  assign lsb_in = 1'b0;
`endif
  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .div_i    (div_q),
    .enable_i (busy_q),
    .restart_i(accept),
    .tick_o   (tick)
  );
  always_comb begin
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    lsb_d = lsb_q;
    div_d = div_q;
    sel_d = sel_q;
    tx_d = tx_q;
    rx_d = rx_q;
    rx_data_d = rx_data_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    accept = (state_q == IDLE || state_q == DONE) && start_i && ({1'b0, slave_sel_i} < NUM_SEL);
    last = bit_q == LAST_BIT;
    lead = tick && (state_q == SETUP || (state_q == SHIFT_TRAIL && !last));
    trail = tick && state_q == SHIFT_LEAD;
    tx_shift = lsb_q ? tx_q >> 1 : tx_q << 1;
    rx_in = lsb_q ? {miso_i, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso_i};
    mosi_src = cpha_q ? tx_q : tx_shift;
    if (accept) begin
      state_d = SETUP;
      cpol_d = cpol_i;
      cpha_d = cpha_i;
      lsb_d = lsb_in;
      div_d = clk_div_i;
      sel_d = slave_sel_i;
      tx_d = tx_data_i;
      rx_d = '0;
      bit_d = '0;
      sclk_d = cpol_i;
      mosi_d = lsb_in ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
    end else if (state_q == IDLE || state_q == DONE) begin
      state_d = IDLE;
      sclk_d = cpol_i;
    end else if (tick) begin
      state_d = state_q == SETUP ? SHIFT_LEAD : state_q == SHIFT_LEAD ? SHIFT_TRAIL :
                state_q == SHIFT_TRAIL ? (last ? HOLD : SHIFT_LEAD) : DONE;
      sclk_d = (lead || trail) ? ~sclk_q : cpol_q;
      bit_d = (state_q == SHIFT_TRAIL && !last) ? bit_q + 1'b1 : bit_q;
      // cpha selects which edge samples and which edge launches the next bit
      if (cpha_q ? trail : lead) rx_d = rx_in;
      if (cpha_q ? lead : trail) begin
        tx_d = tx_shift;
        mosi_d = lsb_q ? mosi_src[0] : mosi_src[DATA_WIDTH-1];
      end
      if (state_q == HOLD) rx_data_d = rx_q;
    end
    busy_d = state_d inside {SETUP, SHIFT_LEAD, SHIFT_TRAIL, HOLD};
    done_d = state_d == DONE;
    ss_n_d = busy_d ? ~(NUM_SLAVES'(1) << sel_d) : '1;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      div_q <= '0;
      sel_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rx_data_q <= '0;
      bit_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ss_n_q <= '1;
    end else begin
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      lsb_q <= lsb_d;
      div_q <= div_d;
      sel_q <= sel_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ss_n_q <= ss_n_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign rx_data_o = rx_data_q;
  assign spi_clk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign ss_n_o = ss_n_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed checks of spi_master_mc against a behavioural SPI slave.
module tb_spi_master_mc;
  import spi_pkg::*;
  logic clk_i = 1'b0;
  logic reset_i, start_i, cpol_i, cpha_i, miso_i;
  logic [7:0] tx_data_i;
  logic [1:0] slave_sel_i;
  logic [7:0] clk_div_i;
  logic busy_o, done_o, spi_clk_o, mosi_o;
  logic [7:0] rx_data_o;
  logic [2:0] ss_n_o;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first_i = 1'b0;
`endif
  int checks = 0, errors = 0;
  int rise_cnt = 0, fall_cnt = 0, done_cnt = 0, slv_idx = 0;
  int cyc, r0, f0, d0, n;
  logic [7:0] slave_word = 8'h00, mosi_cap = 8'h00;
  logic [2:0] ss1;
  logic busy1;
  logic ss_idle;
  spi_master_mc dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .tx_data_i  (tx_data_i),
    .slave_sel_i(slave_sel_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .clk_div_i  (clk_div_i),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first_i(lsb_first_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rx_data_o  (rx_data_o),
    .spi_clk_o  (spi_clk_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .ss_n_o     (ss_n_o)
  );
  always #5 clk_i = ~clk_i;
  assign ss_idle = &ss_n_o;
  assign miso_i = slv_idx < 8 ? slave_word[3'(7 - slv_idx)] : 1'b0;
  // every tested mode samples on the rising SPI edge, so the slave advances there
  always @(posedge spi_clk_o or posedge ss_idle) if (ss_idle) slv_idx = 0; else slv_idx++;
  always @(posedge spi_clk_o) begin
    rise_cnt++;
    mosi_cap = {mosi_cap[6:0], mosi_o};
  end
  always @(negedge spi_clk_o) fall_cnt++;
  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic wait_done(input bit hold, output int c, output logic [2:0] s1, output logic b1);
    c = 0;
    s1 = 3'bxxx;
    b1 = 1'bx;
    do begin
      @(posedge clk_i);
      #1;
      c++;
      if (c == 1) begin
        s1 = ss_n_o;
        b1 = busy_o;
        if (!hold) start_i = 1'b0;
        tx_data_i = ~tx_data_i;
        clk_div_i = 8'd0;
        slave_sel_i = 2'd2;
      end
    end while (done_o !== 1'b1 && c < 2000);
  endtask
  initial begin
    reset_i = 1'b1; start_i = 1'b0; tx_data_i = 8'h00; slave_sel_i = 2'd0;
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd0;
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rx", rx_data_o, 0);
    check("rst_sclk", spi_clk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_ss", ss_n_o, 3'b111);
    reset_i = 1'b0;
    tick(2);
    {cpol_i, cpha_i} = SPI_MODE0; clk_div_i = 8'd0; slave_sel_i = 2'd1; tx_data_i = 8'hA5; slave_word = 8'h3C;
    r0 = rise_cnt;
    start_i = 1'b1;
    wait_done(1'b0, cyc, ss1, busy1);
    check("m0_ss", ss1, 3'b101);
    check("m0_busy", busy1, 1);
    check("m0_done_cycle", cyc, 19);
    check("m0_rx", rx_data_o, 8'h3C);
    check("m0_mosi_seq", mosi_cap, 8'hA5);
    check("m0_rises", rise_cnt - r0, 8);
    check("m0_ss_done", ss_n_o, 3'b111);
    check("m0_busy_done", busy_o, 0);
    tick();
    check("m0_rx_hold", rx_data_o, 8'h3C);
    check("m0_done_pulse", done_o, 0);
    {cpol_i, cpha_i} = SPI_MODE3; clk_div_i = 8'd3; slave_sel_i = 2'd0; tx_data_i = 8'hFF; slave_word = 8'h81;
    tick(2);
    check("m3_idle_high", spi_clk_o, 1);
    f0 = fall_cnt;
    start_i = 1'b1;
    wait_done(1'b0, cyc, ss1, busy1);
    check("m3_ss", ss1, 3'b110);
    check("m3_done_cycle", cyc, 73);
    check("m3_rx", rx_data_o, 8'h81);
    check("m3_falls", fall_cnt - f0, 8);
    check("m3_mosi_seq", mosi_cap, 8'hFF);
    tick(2);
    check("m3_idle_high_after", spi_clk_o, 1);
    {cpol_i, cpha_i} = SPI_MODE0; clk_div_i = 8'd0; slave_sel_i = 2'd2; tx_data_i = 8'h5A; slave_word = 8'h00;
    tick(2);
    d0 = done_cnt;
    start_i = 1'b1;
    wait_done(1'b1, cyc, ss1, busy1);
    check("b2b_first_done", cyc, 19);
    tick();
    check("b2b_setup_busy", busy_o, 1);
    check("b2b_setup_ss", ss_n_o, 3'b011);
    start_i = 1'b0;
    wait_done(1'b0, cyc, ss1, busy1);
    check("b2b_second_done", cyc, 18);
    tick(5);
    check("b2b_pulses", done_cnt - d0, 2);
    clk_div_i = 8'd3; slave_sel_i = 2'd1; tx_data_i = 8'hC3;
    d0 = done_cnt;
    r0 = rise_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 4 && n < 500) begin
      tick();
      n++;
    end
    check("rst_mid_bit4", rise_cnt - r0, 4);
    reset_i = 1'b1;
    tick();
    check("rst_mid_ss", ss_n_o, 3'b111);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_sclk", spi_clk_o, 0);
    check("rst_mid_rx", rx_data_o, 0);
    reset_i = 1'b0;
    tick(80);
    check("rst_mid_no_done", done_cnt - d0, 0);
    clk_div_i = 8'd0; slave_sel_i = 2'd3;
    d0 = done_cnt;
    start_i = 1'b1;
    tick(4);
    check("bad_sel_busy", busy_o, 0);
    check("bad_sel_ss", ss_n_o, 3'b111);
    start_i = 1'b0;
    tick(3);
    check("bad_sel_no_done", done_cnt - d0, 0);
`ifdef SPI_LSB_FIRST_EN
    lsb_first_i = 1'b1;
    {cpol_i, cpha_i} = SPI_MODE0; slave_sel_i = 2'd0; tx_data_i = 8'h01; slave_word = 8'h80;
    start_i = 1'b1;
    wait_done(1'b0, cyc, ss1, busy1);
    check("lsb_mosi_seq", mosi_cap, 8'h80);
    check("lsb_rx", rx_data_o, 8'h01);
    lsb_first_i = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
